// File: rtl/fix_checksum_tx.sv
// Transmit-side FIX trailer generator: passes body bytes through untouched while
// summing them mod 256, then appends "10=DDD<SOH>" built from the frozen sum.
module fix_checksum_tx #(
  parameter logic [7:0] SOH_CHAR = 8'h01,
  parameter logic [7:0] INIT_SUM = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       start_i,
  input  logic       end_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       eof_o,
  output logic [7:0] checksum_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [3:0] {
    IDLE,
    BODY,
    T_1,
    T_0,
    T_EQ,
    D_H,
    D_T,
    D_U,
    T_SOH
  } state_t;

  state_t     state;
  logic [7:0] sum;
  logic [7:0] dig_h;
  logic [7:0] dig_t;
  logic [7:0] dig_u;
  logic [7:0] trailer_byte;

  // Sum is frozen for the whole trailer, so the decimal split is purely combinational.
  assign dig_h = 8'h30 + (sum / 8'd100);
  assign dig_t = 8'h30 + ((sum / 8'd10) % 8'd10);
  assign dig_u = 8'h30 + (sum % 8'd10);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    trailer_byte = SOH_CHAR;
    case (state)
      T_1:     trailer_byte = 8'h31;
      T_0:     trailer_byte = 8'h30;
      T_EQ:    trailer_byte = 8'h3D;
      D_H:     trailer_byte = dig_h;
      D_T:     trailer_byte = dig_t;
      D_U:     trailer_byte = dig_u;
      default: trailer_byte = SOH_CHAR;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    data_o  = 8'h00;
    eof_o   = 1'b0;
    done_o  = 1'b0;
    err_o   = 1'b0;
    case (state)
      IDLE: begin
        data_o = data_i;
        if (valid_i && !start_i) begin
          // Stray byte outside a frame: swallow it and flag the error.
          ready_o = 1'b1;
          err_o   = 1'b1;
        end else begin
          ready_o = ready_i;
          valid_o = valid_i;
        end
      end
      BODY: begin
        ready_o = ready_i;
        valid_o = valid_i;
        data_o  = data_i;
        err_o   = valid_i && start_i && ready_i;
      end
      default: begin
        valid_o = 1'b1;
        data_o  = trailer_byte;
        eof_o   = (state == T_SOH);
        done_o  = (state == T_SOH) && ready_i;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sum        <= INIT_SUM;
      checksum_o <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && start_i && ready_i) begin
            sum   <= INIT_SUM + data_i;
            state <= end_i ? T_1 : BODY;
          end
        end
        BODY: begin
          if (valid_i && ready_i) begin
            // A start inside a body reseeds the sum; the aborted frame gets no trailer.
            if (start_i) begin
              sum <= INIT_SUM + data_i;
            end else begin
              sum <= sum + data_i;
            end
            if (end_i) begin
              state <= T_1;
            end
          end
        end
        T_1:  if (ready_i) state <= T_0;
        T_0:  if (ready_i) state <= T_EQ;
        T_EQ: if (ready_i) state <= D_H;
        D_H:  if (ready_i) state <= D_T;
        D_T:  if (ready_i) state <= D_U;
        D_U:  if (ready_i) state <= T_SOH;
        T_SOH: begin
          if (ready_i) begin
            checksum_o <= sum;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_checksum_tx.sv
// Self-checking bench for fix_checksum_tx: drives frames, collects every output
// transfer and compares against a string-built model of "body + 10=DDD<SOH>".
module tb_fix_checksum_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       start_i = 1'b0;
  logic       end_i = 1'b0;
  logic       ready_i = 1'b1;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       eof_o;
  logic [7:0] checksum_o;
  logic       done_o;
  logic       err_o;

  always #5 clk = ~clk;

  fix_checksum_tx dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .start_i   (start_i),
    .end_i     (end_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .eof_o     (eof_o),
    .checksum_o(checksum_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         cyc = 0;
  logic [7:0] out_q[$];
  logic       out_eof_q[$];
  int         cyc_q[$];
  logic [7:0] exp_q[$];
  logic       exp_eof_q[$];
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         last_done_cyc = 0;
  int         stall_viol = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_d = 8'h00;
  logic       prev_e = 1'b0;
  bit         ready_pat[$];
  bit         rand_ready = 0;
  logic [7:0] body_q[$];
  int         restart_at = -1;
  int         model_sum = 0;

  always @(posedge clk) cyc++;

  // Downstream ready: scripted pattern first, else random or always-ready.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ready_pat.size() > 0) ready_i = ready_pat.pop_front();
      else if (rand_ready) ready_i = 1'($urandom_range(0, 1));
      else ready_i = 1'b1;
    end
  end

  // Output monitor: records transfers, pulses and hold-stability under stall.
  always @(negedge clk) begin
    if (rst) begin
      if (valid_o && ready_i) begin
        out_q.push_back(data_o);
        out_eof_q.push_back(eof_o);
        cyc_q.push_back(cyc);
      end
      if (done_o) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (err_o) err_cnt++;
      if (prev_stall && (!valid_o || data_o !== prev_d || eof_o !== prev_e)) stall_viol++;
      prev_stall = valid_o && !ready_i;
      prev_d     = data_o;
      prev_e     = eof_o;
    end else begin
      prev_stall = 0;
    end
  end

  function automatic int first_diff();
    if (out_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) begin
      if (out_q[i] !== exp_q[i] || out_eof_q[i] !== exp_eof_q[i]) return i;
    end
    return -1;
  endfunction

  task automatic clear_q();
    out_q.delete();
    out_eof_q.delete();
    cyc_q.delete();
    exp_q.delete();
    exp_eof_q.delete();
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic s, input logic e);
    bit got = 0;
    data_i  = d;
    start_i = s;
    end_i   = e;
    valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    start_i = 1'b0;
    end_i   = 1'b0;
    total_cnt++;
    if (!got) $display("FAIL byte_accept_timeout: byte %02h never accepted", d);
    else pass_cnt++;
  endtask

  // Model: body bytes pass through; trailer is "10=" + zero-padded decimal sum + SOH.
  task automatic drive_frame();
    int    s = 0;
    string t;
    foreach (body_q[i]) begin
      if (i == 0 || i == restart_at) s = 0;
      s = (s + int'(body_q[i])) % 256;
      exp_q.push_back(body_q[i]);
      exp_eof_q.push_back(1'b0);
    end
    model_sum = s;
    t = {"10=", $sformatf("%03d", s)};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(t[i]);
      exp_eof_q.push_back(1'b0);
    end
    exp_q.push_back(8'h01);
    exp_eof_q.push_back(1'b1);
    foreach (body_q[i]) begin
      drive_byte(body_q[i], (i == 0 || i == restart_at), (i == body_q.size() - 1));
    end
  endtask

  task automatic wait_done(input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
    end
    total_cnt++;
    if (!got) $display("FAIL done_timeout: no done_o within %0d cycles", budget);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    total_cnt++;
    if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b exp 0", valid_o);
    else pass_cnt++;
    total_cnt++;
    if (checksum_o !== 8'h00) $display("FAIL reset_checksum: got %02h exp 00", checksum_o);
    else pass_cnt++;
    total_cnt++;
    if ({eof_o, done_o, err_o} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {eof_o, done_o, err_o});
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int d0;
    clear_q();
    d0 = done_cnt;
    body_q = '{8'h38, 8'h3D, 8'h41, 8'h01};
    restart_at = -1;
    drive_frame();
    wait_done(50);
    total_cnt++;
    if (first_diff() != -1) $display("FAIL basic_stream: diff at %0d got %0d bytes exp %0d", first_diff(), out_q.size(), exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if (checksum_o !== 8'(model_sum)) $display("FAIL basic_checksum: got %02h exp %02h", checksum_o, 8'(model_sum));
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 != 1) $display("FAIL basic_done_count: got %0d exp 1", done_cnt - d0);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done_o !== 1'b0) $display("FAIL basic_done_width: got %b exp 0", done_o);
    else pass_cnt++;
    total_cnt++;
    if (cyc_q.size() < 11) $display("FAIL basic_timing: got %0d transfers exp 11", cyc_q.size());
    else if (cyc_q[4] != cyc_q[3] + 1 || cyc_q[10] != cyc_q[4] + 6)
      $display("FAIL basic_timing: end@%0d t1@%0d soh@%0d", cyc_q[3], cyc_q[4], cyc_q[10]);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    clear_q();
    body_q = '{8'hFF, 8'hFF, 8'h02};
    restart_at = -1;
    drive_frame();
    wait_done(50);
    total_cnt++;
    if (first_diff() != -1) $display("FAIL wrap_stream: diff at %0d", first_diff());
    else pass_cnt++;
    total_cnt++;
    if (checksum_o !== 8'h00) $display("FAIL wrap_checksum: got %02h exp 00", checksum_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int d1;
    clear_q();
    body_q = '{8'h01};
    restart_at = -1;
    drive_frame();
    wait_done(50);
    d1 = last_done_cyc;
    total_cnt++;
    if (checksum_o !== 8'h01) $display("FAIL single_checksum: got %02h exp 01", checksum_o);
    else pass_cnt++;
    body_q.delete();
    for (int i = 0; i < 5; i++) body_q.push_back(8'($urandom));
    drive_frame();
    wait_done(50);
    total_cnt++;
    if (first_diff() != -1) $display("FAIL b2b_stream: diff at %0d", first_diff());
    else pass_cnt++;
    total_cnt++;
    if (cyc_q.size() < 9 || cyc_q[8] != d1 + 1) $display("FAIL b2b_start_cycle: got %0d exp %0d", (cyc_q.size() < 9) ? -1 : cyc_q[8], d1 + 1);
    else pass_cnt++;
    total_cnt++;
    if (checksum_o !== 8'(model_sum)) $display("FAIL b2b_checksum: got %02h exp %02h", checksum_o, 8'(model_sum));
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int ro_viol = 0;
    bit got = 0;
    int n;
    clear_q();
    body_q = '{8'h41, 8'h42, 8'h43, 8'h01};
    restart_at = -1;
    drive_frame();
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready_o !== 1'b0) ro_viol++;
      if (done_o) begin
        got = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    total_cnt++;
    if (!got) $display("FAIL bp_done_timeout: no done_o");
    else pass_cnt++;
    total_cnt++;
    if (ro_viol != 0) $display("FAIL bp_ready_o: got %0d cycles with ready_o=1 exp 0", ro_viol);
    else pass_cnt++;
    total_cnt++;
    if (first_diff() != -1) $display("FAIL bp_stream: diff at %0d", first_diff());
    else pass_cnt++;
    n = cyc_q.size();
    total_cnt++;
    if (n < 11 || cyc_q[n-1] - cyc_q[4] != 8) $display("FAIL bp_span: got %0d exp 8", (n < 11) ? -1 : cyc_q[n-1] - cyc_q[4]);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    int e0;
    clear_q();
    e0 = err_cnt;
    data_i  = 8'hAA;
    start_i = 1'b0;
    valid_i = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({err_o, valid_o, ready_o} !== 3'b101) $display("FAIL stray_flags: got err/valid/ready %b exp 101", {err_o, valid_o, ready_o});
    else pass_cnt++;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (err_o !== 1'b0) $display("FAIL stray_err_width: got %b exp 0", err_o);
    else pass_cnt++;
    @(posedge clk);
    #1;
    body_q = '{8'h11, 8'h22, 8'h38, 8'h3D, 8'h41, 8'h01};
    restart_at = 2;
    drive_frame();
    restart_at = -1;
    wait_done(50);
    total_cnt++;
    if (first_diff() != -1) $display("FAIL restart_stream: diff at %0d", first_diff());
    else pass_cnt++;
    total_cnt++;
    if (checksum_o !== 8'(model_sum)) $display("FAIL restart_checksum: got %02h exp %02h", checksum_o, 8'(model_sum));
    else pass_cnt++;
    total_cnt++;
    if (err_cnt - e0 != 2) $display("FAIL err_count: got %0d exp 2", err_cnt - e0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    rand_ready = 1;
    for (int f = 0; f < 8; f++) begin
      clear_q();
      body_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 16)); i++) body_q.push_back(8'($urandom));
      restart_at = -1;
      drive_frame();
      wait_done(400);
      total_cnt++;
      if (first_diff() != -1) $display("FAIL rand_stream[%0d]: diff at %0d", f, first_diff());
      else pass_cnt++;
      total_cnt++;
      if (checksum_o !== 8'(model_sum)) $display("FAIL rand_checksum[%0d]: got %02h exp %02h", f, checksum_o, 8'(model_sum));
      else pass_cnt++;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    int    d0;
    string t;
    clear_q();
    body_q = '{8'h38, 8'h3D, 8'h41, 8'h01};
    restart_at = -1;
    drive_frame();
    d0 = done_cnt;
    t = $sformatf("%03d", model_sum);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    total_cnt++;
    if (valid_o !== 1'b1 || data_o !== 8'(t[1])) $display("FAIL mid_dt_byte: got %02h exp %02h", data_o, 8'(t[1]));
    else pass_cnt++;
    #1;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (valid_o !== 1'b0 || eof_o !== 1'b0) $display("FAIL mid_reset_valid: got %b exp 0", valid_o);
    else pass_cnt++;
    total_cnt++;
    if (checksum_o !== 8'h00) $display("FAIL mid_reset_checksum: got %02h exp 00", checksum_o);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (done_cnt != d0) $display("FAIL mid_reset_done: got %0d extra pulses exp 0", done_cnt - d0);
    else pass_cnt++;
    clear_q();
    drive_frame();
    wait_done(50);
    total_cnt++;
    if (first_diff() != -1) $display("FAIL post_reset_stream: diff at %0d", first_diff());
    else pass_cnt++;
    total_cnt++;
    if (checksum_o !== 8'hB7) $display("FAIL post_reset_checksum: got %02h exp b7", checksum_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_random();
    test_reset_mid();
    total_cnt++;
    if (stall_viol != 0) $display("FAIL hold_stable: got %0d violations exp 0", stall_viol);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fix_checksum_tx.md
Name: fix_checksum_tx

Overview:
- Transmit-side FIX trailer generator; it sits between the outbound message assembler and the byte serializer.
- Passes message bytes through unchanged and accumulates the FIX CheckSum, which is the sum of all bytes modulo 256.
- After the last body byte it appends the trailer "10=DDD<SOH>", where DDD is the checksum as three ASCII decimal digits, zero-padded.
- It is the counterpart of the receive-side checksum checker; frames it emits must verify there.

Parameters:
- SOH_CHAR, 8'h01, field delimiter appended after the digits.
- INIT_SUM, 8'h00, accumulator seed loaded at frame start.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_i  in  8  body byte from assembler.
- valid_i  in  1  data_i valid.
- start_i  in  1  marks first body byte ("8"); qualified by valid_i.
- end_i  in  1  marks last body byte (the SOH before "10="); qualified by valid_i.
- ready_o  out  1  block accepts data_i this cycle.
- data_o  out  8  outbound byte.
- valid_o  out  1  data_o valid.
- ready_i  in  1  downstream accepts data_o.
- eof_o  out  1  data_o is the final trailer SOH.
- checksum_o  out  8  last completed checksum (binary), held until next frame ends.
- done_o  out  1  one-cycle pulse when final trailer SOH transfers.
- err_o  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset (rst=0, async): state=IDLE, sum=INIT_SUM, checksum_o=0, valid_o=0, eof_o=0, done_o=0, err_o=0.
- Transfer rule: a transfer occurs on a cycle with valid && ready; output is valid/ready, hold-stable.
- Once valid_o=1, data_o and eof_o must not change until ready_i=1.
- States: IDLE, BODY, T_1, T_0, T_EQ, D_H, D_T, D_U, T_SOH.
- IDLE and BODY (pass-through, zero latency):
  - ready_o=ready_i; valid_o=valid_i; data_o=data_i.
- IDLE:
  - Bytes with valid_i && !start_i are dropped: ready_o=1, valid_o=0, err_o pulses.
  - Start byte transfer: sum<=INIT_SUM+data_i mod 256.
  - start_i && end_i together: go to T_1; otherwise go to BODY.
- BODY:
  - Each transfer: sum<=sum+data_i mod 256, 8-bit wrap.
  - Transfer with end_i: go to T_1.
  - start_i in BODY: byte is transferred, sum<=INIT_SUM+data_i, err_o pulses; stay in BODY (frame restart, no trailer for the aborted frame).
- Trailer states:
  - ready_o=0, valid_o=1.
  - Bytes per state: T_1 emits 8'h31, T_0 emits 8'h30, T_EQ emits 8'h3D.
  - D_H emits 8'h30+sum/100, D_T emits 8'h30+(sum/10)%10, D_U emits 8'h30+sum%10.
  - T_SOH emits SOH_CHAR with eof_o=1.
  - Each state advances only on ready_i=1; the trailer is exactly 7 bytes.
- T_SOH transfer: checksum_o<=sum, done_o=1 for one cycle, go to IDLE.
- Latency: body bytes 0 cycles; trailer starts the cycle after the end_i transfer. With ready_i=1 throughout, the trailer occupies 7 consecutive cycles.
- sum is frozen during the trailer; the digit conversion is combinational from the frozen sum (8-bit, max "255").
- Back-to-back frames: start_i is accepted the cycle after the T_SOH transfer (the IDLE cycle).
- Reset mid-trailer: immediate return to IDLE; the partial trailer is abandoned; checksum_o=0.

Test Plan:
- Frame 38,3D,41,01 (start on 38, end on 01), ready_i=1 -> passthrough, then 31,30,3D,31,38,33,01 with eof_o on last; checksum_o=8'hB7 (183), done_o one pulse.
- Wrap: start FF, FF, end 02 -> sum 0x200 mod 256=0 -> trailer digits 30,30,30; checksum_o=00.
- Single byte start_i=end_i=1 data 01 -> trailer digits "001"; next frame starts cleanly one cycle after done_o.
- Backpressure: ready_i toggling 1,0,0,1 during trailer -> data_o held stable while stalled; ready_o=0 throughout trailer; no byte duplicated or skipped.
- Errors: valid_i without start_i in IDLE -> byte dropped, err_o pulse, no output. start_i mid-BODY -> err_o pulse, sum reseeded, trailer reflects only bytes from the new start.
- Async reset asserted during D_T -> valid_o=0 immediately, state IDLE, checksum_o=0; next frame 38,3D,41,01 still yields "183".
